// File: rtl/typedefs_pkg.sv
// Shared types and constants for the genius memory game.
// Holds the FSM state encoding, the latched game configuration and the LFSR seed.
package typedefs_pkg;

  localparam int unsigned LFSR_W    = 16;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_GEN      = 3'd1,
    ST_PLAY_ON  = 3'd2,
    ST_PLAY_OFF = 3'd3,
    ST_WAIT_IN  = 3'd4,
    ST_WIN      = 3'd5,
    ST_LOSE     = 3'd6
  } genius_state_t;

  typedef enum logic {
    MODE_FOLLOW  = 1'b0,
    MODE_COMMAND = 1'b1
  } mode_t;

  typedef enum logic {
    SPEED_SLOW = 1'b0,
    SPEED_FAST = 1'b1
  } speed_t;

  typedef enum logic [1:0] {
    LEVEL_8     = 2'b00,
    LEVEL_16    = 2'b01,
    LEVEL_MAX   = 2'b10,
    LEVEL_MAX_B = 2'b11
  } level_t;

  // Game settings captured when a game starts.
  typedef struct packed {
    mode_t  mode;
    speed_t speed;
    level_t level;
  } game_cfg_t;

endpackage

// File: rtl/genius_lfsr.sv
// Free-running 16-bit maximal-length LFSR (x^16 + x^14 + x^13 + x^11 + 1).
// Ports: clk, rst_n (async active-low, loads seed), out = current LFSR state.
// Seed is non-zero and the polynomial is maximal, so the state never reaches 0.
module genius_lfsr
  import typedefs_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  output logic [LFSR_W-1:0] out
);

  logic fb;

  assign fb = out[15] ^ out[13] ^ out[12] ^ out[10];

  // Advances every cycle regardless of game state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out <= LFSR_SEED;
    end else begin
      out <= {out[14:0], fb};
    end
  end

endmodule

// File: rtl/genius_core.sv
// Genius / Simon memory game core.
// Ports: clk, rst_n (async active-low); start, mode, speed, level (game setup,
// latched on start); btn_valid/btn_color (player press); led (one-hot display),
// score (completed rounds), busy/win/lose status. All outputs are registered.
module genius_core
  import typedefs_pkg::*;
#(
  parameter int unsigned NUM_COLORS = 4,
  parameter int unsigned MAX_LEN    = 32,
  parameter int unsigned T_FAST     = 4,
  parameter int unsigned T_SLOW     = 16,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          mode,
  input  logic                          speed,
  input  logic [1:0]                    level,
  input  logic                          btn_valid,
  input  logic [$clog2(NUM_COLORS)-1:0] btn_color,
  output logic [NUM_COLORS-1:0]         led,
  output logic [$clog2(MAX_LEN):0]      score,
  output logic                          busy,
  output logic                          win,
  output logic                          lose
);

  localparam int unsigned COLOR_W = $clog2(NUM_COLORS);
  localparam int unsigned ADDR_W  = $clog2(MAX_LEN);
  localparam int unsigned LEN_W   = ADDR_W + 1;
  localparam int unsigned T_MAX0  = (T_SLOW > T_FAST) ? T_SLOW : T_FAST;
  localparam int unsigned T_MAX   = (TIMEOUT > T_MAX0) ? TIMEOUT : T_MAX0;
  localparam int unsigned TMR_W   = $clog2(T_MAX + 1);
  localparam logic [NUM_COLORS-1:0] LED_ONE = NUM_COLORS'(1);

  genius_state_t       state, state_d;
  game_cfg_t           cfg, cfg_d;
  logic [LEN_W-1:0]    seq_len, seq_len_d;
  logic [LEN_W-1:0]    score_d;
  logic [ADDR_W-1:0]   play_idx, play_idx_d;
  logic [ADDR_W-1:0]   match_idx, match_idx_d;
  logic [TMR_W-1:0]    tmr, tmr_d;
  logic [TMR_W-1:0]    t_last;
  logic [LEN_W-1:0]    target;

  logic [NUM_COLORS-1:0] led_d;
  logic                  busy_d, win_d, lose_d;

  logic [COLOR_W-1:0]  mem [MAX_LEN];
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [COLOR_W-1:0]  mem_wdata;
  logic [COLOR_W-1:0]  match_rdata;
  logic [COLOR_W-1:0]  play_rdata;

  logic [LFSR_W-1:0]   lfsr;
  logic                lfsr_unused;

  genius_lfsr u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .out   (lfsr)
  );

  // Only the low colour bits feed the sequence.
  assign lfsr_unused = ^lfsr[LFSR_W-1:COLOR_W];

  // Last timer value of an LED on/off phase for the latched speed.
  assign t_last = (cfg.speed == SPEED_FAST) ? TMR_W'(T_FAST - 1) : TMR_W'(T_SLOW - 1);

  // Target sequence length for the latched level.
  always_comb begin
    case (cfg.level)
      LEVEL_8:  target = LEN_W'(8);
      LEVEL_16: target = LEN_W'(16);
      default:  target = LEN_W'(MAX_LEN);
    endcase
  end

  assign mem_waddr   = seq_len[ADDR_W-1:0];
  assign match_rdata = mem[match_idx];

  // Next-state and counter logic.
  always_comb begin
    state_d     = state;
    cfg_d       = cfg;
    seq_len_d   = seq_len;
    score_d     = score;
    play_idx_d  = play_idx;
    match_idx_d = match_idx;
    tmr_d       = tmr;
    mem_we      = 1'b0;
    mem_wdata   = lfsr[COLOR_W-1:0];

    case (state)
      ST_IDLE, ST_WIN, ST_LOSE: begin
        if (start) begin
          cfg_d       = game_cfg_t'({mode, speed, level});
          seq_len_d   = '0;
          score_d     = '0;
          play_idx_d  = '0;
          match_idx_d = '0;
          tmr_d       = '0;
          state_d     = ST_GEN;
        end
      end

      ST_GEN: begin
        if ((cfg.mode == MODE_FOLLOW) || btn_valid) begin
          mem_we     = 1'b1;
          mem_wdata  = (cfg.mode == MODE_FOLLOW) ? lfsr[COLOR_W-1:0] : btn_color;
          seq_len_d  = seq_len + LEN_W'(1);
          play_idx_d = '0;
          tmr_d      = '0;
          state_d    = ST_PLAY_ON;
        end
      end

      ST_PLAY_ON: begin
        if (tmr == t_last) begin
          tmr_d   = '0;
          state_d = ST_PLAY_OFF;
        end else begin
          tmr_d = tmr + TMR_W'(1);
        end
      end

      ST_PLAY_OFF: begin
        if (tmr == t_last) begin
          tmr_d      = '0;
          play_idx_d = play_idx + ADDR_W'(1);
          if ({1'b0, play_idx} == (seq_len - LEN_W'(1))) begin
            match_idx_d = '0;
            state_d     = ST_WAIT_IN;
          end else begin
            state_d = ST_PLAY_ON;
          end
        end else begin
          tmr_d = tmr + TMR_W'(1);
        end
      end

      ST_WAIT_IN: begin
        // A press on the expiry cycle wins over the timeout.
        if (btn_valid) begin
          tmr_d = '0;
          if (btn_color != match_rdata) begin
            state_d = ST_LOSE;
          end else if ({1'b0, match_idx} == (seq_len - LEN_W'(1))) begin
            score_d = seq_len;
            state_d = (seq_len == target) ? ST_WIN : ST_GEN;
          end else begin
            match_idx_d = match_idx + ADDR_W'(1);
          end
        end else if (tmr == TMR_W'(TIMEOUT - 1)) begin
          state_d = ST_LOSE;
        end else begin
          tmr_d = tmr + TMR_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Playback colour for the next cycle; bypasses the entry being written this cycle.
  always_comb begin
    if (mem_we && (mem_waddr == play_idx_d)) begin
      play_rdata = mem_wdata;
    end else begin
      play_rdata = mem[play_idx_d];
    end
  end

  // Output values computed from the next state so they line up with the state register.
  always_comb begin
    led_d  = '0;
    busy_d = !(state_d inside {ST_IDLE, ST_WIN, ST_LOSE});
    win_d  = (state_d == ST_WIN);
    lose_d = (state_d == ST_LOSE);
    case (state_d)
      ST_PLAY_ON: led_d = LED_ONE << play_rdata;
      ST_WIN:     led_d = '1;
      default:    led_d = '0;
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cfg       <= '0;
      seq_len   <= '0;
      score     <= '0;
      play_idx  <= '0;
      match_idx <= '0;
      tmr       <= '0;
      led       <= '0;
      busy      <= 1'b0;
      win       <= 1'b0;
      lose      <= 1'b0;
    end else begin
      state     <= state_d;
      cfg       <= cfg_d;
      seq_len   <= seq_len_d;
      score     <= score_d;
      play_idx  <= play_idx_d;
      match_idx <= match_idx_d;
      tmr       <= tmr_d;
      led       <= led_d;
      busy      <= busy_d;
      win       <= win_d;
      lose      <= lose_d;
    end
  end

  // Sequence memory, no reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

endmodule

// File: doc/genius_core.md
GENIUS_CORE -- requirements
Module: genius_core

Interface
REQ-001 SHALL have parameter NUM_COLORS, default 4, number of colour channels; legal values are 2, 4 and 8.
REQ-002 SHALL have parameter MAX_LEN, default 32, sequence memory depth; it is a power of 2 and at least 16.
REQ-003 SHALL have parameter T_FAST, default 4, LED on/off time in cycles at fast speed.
REQ-004 SHALL have parameter T_SLOW, default 16, LED on/off time in cycles at slow speed.
REQ-005 SHALL have parameter TIMEOUT, default 64, maximum cycles between accepted player presses.
REQ-006 SHALL derive localparams COLOR_W = clog2(NUM_COLORS) and ADDR_W = clog2(MAX_LEN).
REQ-007 clk  in  1  single clock; all logic is on its rising edge.
REQ-008 rst_n  in  1  reset, asynchronous and active-low.
REQ-009 start  in  1  level input, sampled each cycle; starts a game.
REQ-010 mode  in  1  0 = follow (LFSR generates the sequence); 1 = command (player appends items).
REQ-011 speed  in  1  0 = slow (T_SLOW); 1 = fast (T_FAST).
REQ-012 level  in  2  target length: 00 = 8, 01 = 16, 1x = MAX_LEN.
REQ-013 btn_valid  in  1  single-cycle press strobe.
REQ-014 btn_color  in  COLOR_W  pressed colour; qualified by btn_valid.
REQ-015 led  out  NUM_COLORS  one-hot colour display.
REQ-016 score  out  ADDR_W+1  number of completed rounds.
REQ-017 busy  out  1  high in every state except IDLE, WIN and LOSE.
REQ-018 win  out  1  high while in WIN.
REQ-019 lose  out  1  high while in LOSE.

Function
REQ-020 SHALL use the states IDLE, GEN, PLAY_ON, PLAY_OFF, WAIT_IN, WIN and LOSE.
REQ-021 When start=1 in IDLE, WIN or LOSE, the block SHALL latch mode, speed and level, clear seq_len and score, and enter GEN on the next cycle.
REQ-022 start SHALL be ignored in all other states.
REQ-023 In GEN with latched mode=0, the block SHALL write lfsr[COLOR_W-1:0] to mem[seq_len], increment seq_len, clear play_idx, and enter PLAY_ON, all in one cycle.
REQ-024 In GEN with latched mode=1, the block SHALL stay in GEN until btn_valid; on btn_valid it SHALL store btn_color, increment seq_len, clear play_idx, and enter PLAY_ON.
REQ-025 In PLAY_ON, led SHALL be one-hot of mem[play_idx] for exactly T cycles; the block then enters PLAY_OFF.
REQ-026 In PLAY_OFF, led SHALL be 0 for exactly T cycles.
REQ-027 At the end of PLAY_OFF, the block SHALL increment play_idx; if play_idx was seq_len-1 it SHALL clear match_idx, clear the timeout counter, and enter WAIT_IN; otherwise it SHALL return to PLAY_ON.
REQ-028 In WAIT_IN, a btn_valid with btn_color != mem[match_idx] SHALL cause entry to LOSE.
REQ-029 In WAIT_IN, a matching btn_valid with match_idx < seq_len-1 SHALL increment match_idx and reset the timeout counter.
REQ-030 In WAIT_IN, a matching btn_valid with match_idx = seq_len-1 SHALL set score = seq_len; the block then enters WIN if seq_len = target, otherwise GEN.
REQ-031 In WAIT_IN, TIMEOUT consecutive cycles without btn_valid SHALL cause entry to LOSE; a btn_valid on the expiry cycle takes priority over the timeout.
REQ-032 btn_valid SHALL be ignored in IDLE, PLAY_ON, PLAY_OFF, WIN, LOSE, and in GEN when mode=0.
REQ-033 led SHALL be all-ones in WIN, and 0 in IDLE, LOSE, GEN and WAIT_IN.
REQ-034 The LFSR SHALL be 16-bit maximal-length (taps 16,14,13,11), advance every cycle in every state, and never reach 0.
REQ-035 Memory reads SHALL be combinational or registered; either way, led timing SHALL meet REQ-025 exactly.
REQ-036 seq_len SHALL never exceed the target length, so memory addresses never wrap.

Reset
REQ-037 While rst_n=0, the block SHALL be in IDLE with led=0, score=0, busy=0, win=0, lose=0, all counters at 0, and lfsr=16'hACE1.
REQ-038 Reset asserted mid-game SHALL abort the game immediately; memory contents need not be cleared.

Structure
REQ-039 typedefs_pkg SHALL hold genius_state_t, mode_t, speed_t, level_t and the LFSR seed constant.
REQ-040 The LFSR SHALL be a sub-module genius_lfsr (clk, rst_n, out[15:0]).
REQ-041 The sequence memory SHALL be an internal array without reset.

Verification
REQ-042 Follow mode: level=00, speed=1, always press the correct colour -> 8 rounds; score steps 1..8; win=1; round n shows n LED pulses, each 4 on / 4 off cycles.
REQ-043 Follow mode: press a wrong colour at round 3, item 2 -> lose=1 the next cycle, score=2, led=0.
REQ-044 Play to WAIT_IN, then no press for 64 cycles -> lose=1; a correct press at cycle 64 instead -> no lose.
REQ-045 Command mode: enter colours 2, 0, 3 across rounds, echoing correctly -> playback of round 3 shows led 0100, 0001, 1000.
REQ-046 rst_n low during PLAY_ON -> led=0, busy=0 the same cycle; start afterwards -> new game with score=0.
REQ-047 btn_valid pulses during PLAY_ON/PLAY_OFF, and start pulses while busy -> no change to state, score or match progress.
